// File: rtl/iob_timer_master.sv
// Native-bus initiator that turns CLEAR/START/STOP/SAMPLE commands into timer
// register transactions and returns one response (sampled count or timeout).
module iob_timer_master #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 2,
  parameter int ADDR_RESET = 0,
  parameter int ADDR_RUN   = 1,
  parameter int ADDR_DATA  = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  output logic              cmd_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              valid,
  output logic [ADDR_W-1:0] address,
  output logic              wdata,
  output logic              wstrb,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ready
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, GAP, RESP} state_t;
  typedef enum logic [1:0] {OP_CLEAR, OP_START, OP_STOP, OP_SAMPLE} op_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wdata;
    logic              wstrb;
  } txn_t;

  // CLEAR is a two-phase pulse on the reset register; everything else is one access.
  function automatic txn_t txn_for(op_t op, logic ph2);
    txn_t t;
    t = '{addr: '0, wdata: 1'b0, wstrb: 1'b0};
    case (op)
      OP_CLEAR:  t = '{addr: ADDR_W'(ADDR_RESET), wdata: ~ph2, wstrb: 1'b1};
      OP_START:  t = '{addr: ADDR_W'(ADDR_RUN),   wdata: 1'b1, wstrb: 1'b1};
      OP_STOP:   t = '{addr: ADDR_W'(ADDR_RUN),   wdata: 1'b0, wstrb: 1'b1};
      OP_SAMPLE: t = '{addr: ADDR_W'(ADDR_DATA),  wdata: 1'b0, wstrb: 1'b0};
      default:   t = '{addr: '0, wdata: 1'b0, wstrb: 1'b0};
    endcase
    return t;
  endfunction

  state_t            state, state_d;
  op_t               op_q, op_d;
  logic              ph2_q, ph2_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              cmd_ready_d, rsp_valid_d, rsp_err_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic              valid_d;
  txn_t              bus_q, bus_d, t;

  assign address = bus_q.addr;
  assign wdata   = bus_q.wdata;
  assign wstrb   = bus_q.wstrb;

  always_comb begin
    state_d     = state;
    op_d        = op_q;
    ph2_d       = ph2_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    cmd_ready_d = cmd_ready;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err;
    rsp_data_d  = rsp_data;
    valid_d     = valid;
    bus_d       = bus_q;
    t           = txn_for(op_q, 1'b1);
    case (state)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          op_d        = op_t'(cmd_op);
          ph2_d       = 1'b0;
          err_d       = 1'b0;
          cnt_d       = '0;
          rd_d        = '0;
          bus_d       = txn_for(op_t'(cmd_op), 1'b0);
          valid_d     = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (ready) begin
          if (!bus_q.wstrb) rd_d = rdata;
          valid_d = 1'b0;
          state_d = GAP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        // The responder's ready lags valid by a cycle, so whatever it shows here is stale.
        if (op_q == OP_CLEAR && !ph2_q && !err_q) begin
          ph2_d   = 1'b1;
          cnt_d   = '0;
          bus_d   = t;
          valid_d = 1'b1;
          state_d = REQ;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
          rsp_data_d  = (op_q == OP_SAMPLE && !err_q) ? rd_q : '0;
          state_d     = RESP;
        end
      end
      RESP: begin
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op_q      <= OP_CLEAR;
      ph2_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      rd_q      <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      valid     <= 1'b0;
      bus_q     <= '{addr: '0, wdata: 1'b0, wstrb: 1'b0};
    end else begin
      state     <= state_d;
      op_q      <= op_d;
      ph2_q     <= ph2_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_data  <= rsp_data_d;
      valid     <= valid_d;
      bus_q     <= bus_d;
    end
  end

endmodule

// File: doc/iob_timer_master.md
Name: iob_timer_master

Overview:
- Native-bus initiator that drives the timer peripheral's valid/address/wdata/wstrb/rdata/ready port on behalf of a local controller (e.g. a DMA or profiling unit with no CPU access).
- Accepts one-shot commands (CLEAR, START, STOP, SAMPLE) and sequences the required register transactions.
- Returns one response per command: the sampled count, or a timeout error.

Parameters:
- DATA_W, 32, width of rdata and rsp_data.
- ADDR_W, 2, bus address width.
- ADDR_RESET, 0, address of the timer reset register.
- ADDR_RUN, 1, address of the timer run register.
- ADDR_DATA, 2, address of the timer count register.
- TIMEOUT, 16, maximum cycles valid is held without ready before abort; must be ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- cmd_valid  in  1  command request.
- cmd_op  in  2  0=CLEAR, 1=START, 2=STOP, 3=SAMPLE.
- cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  DATA_W  sampled count (SAMPLE only, else 0).
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- valid  out  1  bus request.
- address  out  ADDR_W  bus address.
- wdata  out  1  bus write data.
- wstrb  out  1  1=write, 0=read.
- rdata  in  DATA_W  bus read data.
- ready  in  1  bus acknowledge.

Behaviour:
- All outputs are registered. While rst=0: cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, valid=0, address=0, wdata=0, wstrb=0, FSM=IDLE, timeout counter=0.
- In the first cycle after reset release, cmd_ready=1.
- FSM states: IDLE, REQ, GAP, RESP.
- IDLE
  - cmd_ready=1.
  - On cmd_valid: latch op; load the phase-1 transaction; valid=1 next cycle; go to REQ; cmd_ready=0.
- Transaction table:
  - CLEAR: write ADDR_RESET wdata=1, then write ADDR_RESET wdata=0.
  - START: write ADDR_RUN wdata=1.
  - STOP: write ADDR_RUN wdata=0.
  - SAMPLE: read ADDR_DATA, wstrb=0, wdata=0.
- REQ
  - valid=1; address, wdata and wstrb stay stable until ready is sampled high.
  - The timeout counter increments each REQ cycle with ready=0.
  - On ready=1:
    - For reads, capture rdata.
    - valid=0 next cycle; go to GAP.
  - On counter reaching TIMEOUT-1 with ready=0: valid=0 next cycle; set error; skip any remaining phase; go to GAP.
- GAP
  - Exactly one cycle, valid=0, ready ignored.
  - Required because the responder registers ready from valid, so a stale ready appears here.
  - If CLEAR phase 1 succeeded: load phase 2; go to REQ (valid=1 next cycle); counter cleared.
  - Otherwise go to RESP.
- RESP
  - rsp_valid=1 for one cycle.
  - rsp_data = captured rdata for successful SAMPLE, else 0.
  - rsp_err = error flag.
  - Next cycle: IDLE, cmd_ready=1, rsp_valid=0.
- Latency, no wait states (responder ready one cycle after valid):
  - cmd accept at cycle 0, valid at cycle 1, ready at cycle 2, GAP at cycle 3, rsp_valid at cycle 4, cmd_ready at cycle 5.
  - CLEAR takes 3 cycles longer (rsp_valid at cycle 7).
- Timeout response timing: rsp_valid = accept + TIMEOUT + 2 cycles.
- cmd_valid outside IDLE is ignored; there is no queueing.
- rst asserted mid-transaction: valid drops immediately (asynchronous), all state clears, and no response is issued for the aborted command.
- A ready=1 seen while valid=0 is ignored in every state and causes no state change.

Test Plan:
- START with a responder acking one cycle after valid -> one write: address=1, wdata=1, wstrb=1; rsp_valid at cycle 4 with rsp_err=0, rsp_data=0.
- START, wait 50 cycles, SAMPLE with the responder returning rdata=0x00000033 -> read at address=2 with wstrb=0; rsp_data=0x00000033, rsp_err=0.
- CLEAR -> two writes to address 0 (wdata=1 then wdata=0), separated by one valid=0 cycle; one rsp_valid at cycle 7.
- Responder never asserts ready, TIMEOUT=16, SAMPLE -> valid high for exactly 16 cycles then low; rsp_valid with rsp_err=1, rsp_data=0; cmd_ready returns; stale ready afterwards is ignored.
- Responder returns ready=1 in the GAP cycle, then a CLEAR command is issued -> no duplicate response; the second CLEAR phase still issues its own request.
- rst driven low while valid=1 during STOP -> valid=0 asynchronously; no rsp_valid after release; cmd_ready=1 in the first cycle after reset release.
